// File: rtl/stepper_onehot_prog.sv
// Programmable one-hot step sequencer: prescaled advance with wrap,
// bounce and one-shot modes; drives a one-hot step bus plus pulses.
// Ports: clk, rst_n, en, clr, mode, dir, last, div, start ->
//        step, pos, adv, wrap, busy.
module stepper_onehot_prog #(
  parameter int N     = 29,
  parameter int DIV_W = 8,
  localparam int CW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic [CW-1:0]    last,
  input  logic [DIV_W-1:0] div,
  input  logic             start,
  output logic [N-1:0]     step,
  output logic [CW-1:0]    pos,
  output logic             adv,
  output logic             wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    M_WRAP = 2'b00,
    M_BNC  = 2'b01,
    M_ONE  = 2'b10,
    M_HOLD = 2'b11
  } mode_t;

  localparam logic [CW-1:0] TOP = CW'(N - 1);
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [N-1:0]  BIT0 = N'(1);

  mode_t            m;
  logic [CW-1:0]    lastc;
  logic [CW-1:0]    pos_n;
  logic [N-1:0]     step_n;
  logic [DIV_W-1:0] pre;
  logic [DIV_W-1:0] pre_n;
  logic             up;
  logic             up_n;
  logic             busy_n;
  logic             adv_n;
  logic             wrap_n;
  logic             run;
  logic             tick;

  assign m     = mode_t'(mode);
  assign lastc = (last > TOP) ? TOP : last;

  always_comb begin
    pre_n  = pre;
    pos_n  = pos;
    up_n   = up;
    busy_n = busy;
    adv_n  = 1'b0;
    wrap_n = 1'b0;
    run    = (m == M_WRAP) || (m == M_BNC) ||
             ((m == M_ONE) && busy);
    tick   = run && en && (pre == div);
    if (clr) begin
      pre_n  = '0;
      pos_n  = '0;
      up_n   = 1'b1;
      busy_n = 1'b0;
    end else if ((m == M_ONE) && start && !busy) begin
      pre_n  = '0;
      pos_n  = '0;
      busy_n = 1'b1;
    end else begin
      if (run && en)
        pre_n = tick ? '0 : pre + 1'b1;
      if (tick) begin
        adv_n = 1'b1;
        // out-of-range position (last lowered mid-run) restarts
        if (pos > lastc) begin
          pos_n  = '0;
          wrap_n = 1'b1;
          up_n   = 1'b1;
        end else begin
          unique case (m)
            M_WRAP: begin
              if (!dir) begin
                wrap_n = (pos == lastc);
                pos_n  = wrap_n ? '0 : pos + ONE;
              end else begin
                wrap_n = (pos == '0);
                pos_n  = wrap_n ? lastc : pos - ONE;
              end
            end
            M_BNC: begin
              if (lastc == '0) begin
                wrap_n = 1'b1;
              end else if (up) begin
                if (pos == lastc) begin
                  up_n   = 1'b0;
                  pos_n  = lastc - ONE;
                  wrap_n = 1'b1;
                end else begin
                  pos_n = pos + ONE;
                end
              end else begin
                if (pos == '0) begin
                  up_n   = 1'b1;
                  pos_n  = ONE;
                  wrap_n = 1'b1;
                end else begin
                  pos_n = pos - ONE;
                end
              end
            end
            M_ONE: begin
              if (pos == lastc) begin
                pos_n  = '0;
                wrap_n = 1'b1;
                busy_n = 1'b0;
              end else begin
                pos_n = pos + ONE;
              end
            end
            M_HOLD: begin
            end
            default: begin
            end
          endcase
        end
      end
      if (m != M_ONE)
        busy_n = 1'b0;
    end
    step_n = BIT0 << pos_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= '0;
      step <= BIT0;
      pre  <= '0;
      up   <= 1'b1;
      busy <= 1'b0;
      adv  <= 1'b0;
      wrap <= 1'b0;
    end else begin
      pos  <= pos_n;
      step <= step_n;
      pre  <= pre_n;
      up   <= up_n;
      busy <= busy_n;
      adv  <= adv_n;
      wrap <= wrap_n;
    end
  end

endmodule

// File: tb/tb_stepper_onehot_prog.sv
// Bench for stepper_onehot_prog: behavioural model compared every
// cycle, directed literal sequences, then randomized stimulus.
module tb_stepper_onehot_prog;

  localparam int N  = 29;
  localparam int CW = $clog2(N);
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          en    = 1'b0;
  logic          clr   = 1'b0;
  logic          dir   = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode  = 2'b00;
  logic [CW-1:0] last  = '0;
  logic [DW-1:0] div   = '0;
  logic [N-1:0]  step;
  logic [CW-1:0] pos;
  logic          adv;
  logic          wrap;
  logic          busy;

  int n_chk  = 0;
  int n_fail = 0;

  int m_pos;
  int m_pre;
  bit m_up;
  bit m_busy;
  bit m_adv;
  bit m_wrap;

  always #5 clk = ~clk;

  stepper_onehot_prog #(.N(N), .DIV_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .mode  (mode),
    .dir   (dir),
    .last  (last),
    .div   (div),
    .start (start),
    .step  (step),
    .pos   (pos),
    .adv   (adv),
    .wrap  (wrap),
    .busy  (busy)
  );

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_pre  = 0;
    m_up   = 1;
    m_busy = 0;
    m_adv  = 0;
    m_wrap = 0;
  endtask

  // one clock edge of the sequencer, from the rules
  task automatic model_step();
    int  lc;
    bit  ok;
    bit  a;
    a      = 0;
    m_adv  = 0;
    m_wrap = 0;
    lc = (int'(last) > N - 1) ? N - 1 : int'(last);
    if (clr) begin
      model_reset();
    end else if (mode == 2 && start && !m_busy) begin
      m_pos  = 0;
      m_pre  = 0;
      m_busy = 1;
    end else begin
      ok = (mode == 0) || (mode == 1) ||
           (mode == 2 && m_busy);
      if (ok && en) begin
        if (m_pre == int'(div)) begin
          m_pre = 0;
          a     = 1;
        end else begin
          m_pre = m_pre + 1;
        end
      end
      if (a) begin
        m_adv = 1;
        if (m_pos > lc) begin
          m_pos  = 0;
          m_wrap = 1;
          m_up   = 1;
        end else if (mode == 0) begin
          if (dir == 0) begin
            m_wrap = (m_pos >= lc);
            m_pos  = m_wrap ? 0 : m_pos + 1;
          end else begin
            m_wrap = (m_pos == 0);
            m_pos  = m_wrap ? lc : m_pos - 1;
          end
        end else if (mode == 1) begin
          if (lc == 0) begin
            m_wrap = 1;
          end else if (m_up && m_pos == lc) begin
            m_up   = 0;
            m_pos  = lc - 1;
            m_wrap = 1;
          end else if (!m_up && m_pos == 0) begin
            m_up   = 1;
            m_pos  = 1;
            m_wrap = 1;
          end else begin
            m_pos = m_up ? m_pos + 1 : m_pos - 1;
          end
        end else begin
          m_wrap = (m_pos == lc);
          m_pos  = m_wrap ? 0 : m_pos + 1;
          if (m_wrap) m_busy = 0;
        end
      end
      if (mode != 2) m_busy = 0;
    end
  endtask

  task automatic compare_model();
    logic [63:0] oh;
    oh = 64'(1) << m_pos;
    chk("pos", pos, m_pos);
    chk("step", step, oh);
    chk("adv", adv, m_adv);
    chk("wrap", wrap, m_wrap);
    chk("busy", busy, m_busy);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic do_clr();
    clr = 1;
    cyc();
    clr = 0;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_pos"}, pos, 0);
    chk({nm, "_step"}, step, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_adv"}, adv, 0);
    chk({nm, "_wrap"}, wrap, 0);
  endtask

  int dexp [6] = '{5, 4, 3, 2, 1, 0};
  int bexp [7] = '{1, 2, 3, 2, 1, 0, 1};
  int bwr  [7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    int bcnt;
    int wcnt;
    int mx;
    model_reset();
    #8;
    chk_reset_vals("reset");
    rst_n = 1;

    // full-length wrap, div=0
    mode = 0; div = 0; last = 28; dir = 0; en = 1;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      chk("wrap_seq_pos", pos, i % 29);
      chk("wrap_seq_wrap", wrap, (i % 29) == 0);
    end

    // prescale 4, counting down, wrap point 5
    do_clr();
    div = 3; dir = 1; last = 5;
    for (int k = 0; k < 6; k++) begin
      repeat (3) cyc();
      chk("down_hold_adv", adv, 0);
      cyc();
      chk("down_pos", pos, dexp[k]);
      chk("down_adv", adv, 1);
      chk("down_wrap", wrap, k == 0);
    end
    en = 0;
    repeat (7) cyc();
    chk("en_low_pos", pos, 0);
    en = 1;
    repeat (3) cyc();
    chk("stretch_pos", pos, 0);
    cyc();
    chk("stretch_pos5", pos, 5);
    chk("stretch_wrap", wrap, 1);

    // bounce
    do_clr();
    mode = 1; last = 3; div = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("bnc_pos", pos, bexp[i]);
      chk("bnc_wrap", wrap, bwr[i]);
    end
    last = 0;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bnc0_pos", pos, 0);
      chk("bnc0_adv", adv, 1);
      chk("bnc0_wrap", wrap, 1);
    end

    // one-shot with re-trigger attempt mid-run
    mode = 2; last = 4; div = 1;
    do_clr();
    start = 1;
    cyc();
    start = 0;
    chk("os_busy_rise", busy, 1);
    bcnt = 1; wcnt = 0; mx = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i == 3);
      cyc();
      bcnt += int'(busy);
      wcnt += int'(wrap);
      if (int'(pos) > mx) mx = int'(pos);
    end
    start = 0;
    chk("os_busy_cycles", bcnt, 10);
    chk("os_wraps", wcnt, 1);
    chk("os_max_pos", mx, 4);

    // lower last mid-run, then clamp
    mode = 0; div = 0; last = 28; dir = 0;
    do_clr();
    repeat (20) cyc();
    chk("bnd_pos20", pos, 20);
    last = 7;
    cyc();
    chk("bnd_lower_pos", pos, 0);
    chk("bnd_lower_wrap", wrap, 1);
    last = 31;
    mx = 0;
    for (int i = 0; i < 30; i++) begin
      cyc();
      if (int'(pos) > mx) mx = int'(pos);
    end
    chk("clamp_max", mx, 28);

    // clr aborts a one-shot
    mode = 2; last = 4; div = 1;
    do_clr();
    start = 1;
    cyc();
    start = 0;
    repeat (5) cyc();
    chk("abort_pre_pos", pos, 2);
    do_clr();
    chk("abort_pos", pos, 0);
    chk("abort_busy", busy, 0);
    chk("abort_wrap", wrap, 0);

    // async reset between edges
    mode = 0; div = 0; last = 28;
    repeat (6) cyc();
    #2;
    rst_n = 0;
    #1;
    chk_reset_vals("async");
    model_reset();
    #1;
    rst_n = 1;

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      en    = ($urandom % 5) != 0;
      clr   = ($urandom % 80) == 0;
      start = ($urandom % 6) == 0;
      if ($urandom % 40 == 0) begin
        mode = 2'($urandom);
        dir  = 1'($urandom);
      end
      if ($urandom % 30 == 0) last = CW'($urandom);
      if ($urandom % 40 == 0) div = DW'($urandom % 4);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_onehot_prog.md
# stepper_onehot_prog

Programmable one-hot step sequencer, parametrised successor of the fixed 29-position stepper. Drives an N-bit one-hot `step` bus from a registered position counter. Advance rate comes from a programmable prescaler, wrap point and direction are runtime-selectable, and it supports free-running wrap, ping-pong (bounce) and triggered one-shot modes. It sits between control registers and the display/actuator drivers that consume one-hot phases.

## Interface
Parameters:
- `N`, default 29: number of positions, N ≥ 2. Local `CW = $clog2(N)`.
- `DIV_W`, default 8: prescaler width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  advance enable; prescaler holds while low.
- `clr`  in  1  synchronous return to home.
- `mode`  in  2  00 wrap, 01 bounce, 10 one-shot, 11 hold.
- `dir`  in  1  wrap mode only: 0 up, 1 down.
- `last`  in  CW  highest active position.
- `div`  in  DIV_W  step period = div+1 enabled cycles.
- `start`  in  1  one-shot trigger, level-sampled.
- `step`  out  N  one-hot position.
- `pos`  out  CW  binary position.
- `adv`  out  1  one-cycle pulse, position advanced.
- `wrap`  out  1  one-cycle pulse, wrap/turnaround/sequence end.
- `busy`  out  1  one-shot sequence running.

## Operation
- Reset (async, `rst_n`=0):
  - `pos`=0, `step`=1 (bit 0), prescaler=0, `busy`=0, `adv`=0, `wrap`=0, bounce flag = up.
- Priority per edge: `clr` > `start` > advance.
- `clr`=1:
  - Same state as reset.
  - No pulses.
- Effective wrap point:
  - `lastc` = min(`last`, N-1).
- Prescaler:
  - When counting is permitted, `pre` increments while `en`=1.
  - Advance event when `en`=1 and `pre`==`div`; `pre` then returns to 0.
  - `div`=0 gives an advance every enabled cycle.
  - Counting is permitted in modes 00 and 01 always, in mode 10 only while `busy`=1, and never in mode 11.
- Mode 00, wrap:
  - `dir`=0: `pos`+1; at `pos`≥`lastc` load 0 and pulse `wrap`.
  - `dir`=1: `pos`−1; at `pos`==0 load `lastc` and pulse `wrap`.
- Mode 01, bounce (`dir` ignored):
  - Flag up: `pos`+1. At `pos`==`lastc`, flip the flag, load `lastc`−1 and pulse `wrap`.
  - Flag down: `pos`−1. At `pos`==0, flip the flag, load 1 and pulse `wrap`.
  - `lastc`==0: `pos` stays 0 and `wrap` pulses on every advance.
- Mode 10, one-shot:
  - `start`=1 with `busy`=0: `pos`=0, `pre`=0, `busy`=1.
  - `start` while `busy`=1 is ignored.
  - While busy, advance up. An advance at `pos`==`lastc` loads 0, pulses `wrap` and clears `busy`.
- Mode 11: position and prescaler hold. No pulses.
- Any advance with `pos`>`lastc` (for example after `last` is lowered mid-run) loads 0, pulses `wrap`, and sets the bounce flag to up. This applies in all modes.
- `busy` is forced to 0 whenever `mode`≠10.
- `mode`, `dir` and `last` changes take effect at the next advance. The prescaler is not reset by these changes.
- `adv` pulses on every advance event, including self-loads such as `lastc`==0.
- `step[i]`=1 iff `pos`==i, and exactly one bit is set at all times.

## Timing
- All outputs are registered and update on the same edge as `pos`.
- `adv` and `wrap` are high for exactly the one cycle in which the new `pos` is first visible.
- With `en` held high from a cleared prescaler, the first advance is visible D+1 edges later (D = `div`), then every D+1 cycles.
- `en` low for k cycles stretches the current step by k cycles. No advance is lost or duplicated.
- One-shot:
  - `busy` rises on the edge after `start` is sampled.
  - The first advance follows D+1 edges later.
  - A complete run occupies (`lastc`+1)·(D+1) cycles of `busy`.
- `clr` or `rst_n` mid-run aborts immediately. No `wrap` pulse.

## Test plan
- Reset: N=29, `div`=0, mode 00, `dir`=0, `last`=28, `en`=1 → `pos` 0..28 then 0; `wrap` coincides with `pos`=0; `step` is one-hot every cycle.
- Prescale and direction: `div`=3, `dir`=1, `last`=5 → `pos` steps every 4 cycles through 0,5,4,3,2,1,0; `wrap` on the loads of 5; holding `en` low for 7 cycles delays only.
- Bounce: mode 01, `last`=3, `div`=0 → sequence 0,1,2,3,2,1,0,1; `wrap` on both turnarounds; with `last`=0, `pos` stays 0 and `adv`/`wrap` pulse every cycle.
- One-shot: mode 10, `last`=4, `div`=1 → after `start`, `busy` is high for 10 cycles, `pos` runs 0..4 then 0 with a single `wrap`; a second `start` mid-run is ignored.
- Boundary: at `pos`=20, lower `last` to 7 → next advance gives `pos`=0 with `wrap`; setting `last`=31 with N=29 clamps the wrap point to 28.
- Abort: `clr` mid one-shot → next cycle `pos`=0, `busy`=0, no `wrap`; async `rst_n` pulse between edges → outputs return to reset values immediately.
